axi_frame_writer: RTL and testbench

- AXI4-full write master that drains packed CMOS pixel words from the write-side FIFO and bursts them into frame buffers in DDR.
- Sits directly upstream of the AXI memory slave, inside the stitching top, in the M_AXI_ACLK domain.
- The input is the read port of the cmos-to-AXI async FIFO. That FIFO is first-word-fall-through: data is valid whenever fifo_rd_cnt > 0.
- Frames rotate through FRAME_BUF_NUM buffers so the video read path can consume a completed frame.

---
 rtl/axi_frame_writer.sv | 216 +++++++++++++++++++++
 tb/tb_axi_frame_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_frame_writer.sv
// axi_frame_writer
// AXI4-full write master: drains packed pixel words from a first-word-fall-
// through FIFO and writes them as fixed-length INCR bursts into rotating frame
// buffers in DDR. Exactly one burst is in flight at a time (AW, then W, then B).
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN   clock, async active-low reset
//   frame_start                  pulse: first word of a new frame is at FIFO head
//   fifo_rd_data / fifo_rd_cnt   FWFT head word and fill level
//   fifo_rd_en                   pop strobe (= WVALID & WREADY)
//   wr_frame_idx                 buffer currently being written
//   wr_frame_done                pulse on the B handshake that completes a frame
//   wr_err                       sticky, set on any BRESP != OKAY
//   M_AXI_AW* / M_AXI_W* / M_AXI_B*   AXI4 write channels
//
// Optional build macro AXI_FRAME_WRITER_STATS_EN adds burst_total and
// frame_abort_cnt saturating counters.
module axi_frame_writer #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
    parameter int          C_M_AXI_BURST_LEN          = 128,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 128,
    parameter int          C_M_AXI_AWUSER_WIDTH       = 1,
    parameter int          C_M_AXI_WUSER_WIDTH        = 1,
    parameter int          C_M_AXI_BUSER_WIDTH        = 1,
    parameter int          FRAME_BURSTS               = 1800,
    parameter logic [31:0] FRAME_STRIDE               = 32'h00400000,
    parameter int          FRAME_BUF_NUM              = 3
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              frame_start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     fifo_rd_data,
    input  logic [11:0]                       fifo_rd_cnt,
    output logic                              fifo_rd_en,
    output logic [1:0]                        wr_frame_idx,
    output logic                              wr_frame_done,
    output logic                              wr_err,
`ifdef AXI_FRAME_WRITER_STATS_EN
    output logic [31:0]                       burst_total,
    output logic [15:0]                       frame_abort_cnt,
`endif
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic [C_M_AXI_AWUSER_WIDTH-1:0]   M_AXI_AWUSER,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic [C_M_AXI_WUSER_WIDTH-1:0]    M_AXI_WUSER,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic [C_M_AXI_BUSER_WIDTH-1:0]    M_AXI_BUSER,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);
    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int BURST_BYTES = C_M_AXI_BURST_LEN * C_M_AXI_DATA_WIDTH / 8;
    localparam int BEAT_W      = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
    localparam int BC_W        = $clog2(FRAME_BURSTS + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AW, S_W, S_B} state_t;

    state_t            state_q;
    logic [AW-1:0]     addr_q;
    logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [BEAT_W-1:0] beat_q;
    logic [1:0]        idx_q, idx_d;
    logic              pend_q;
    logic              awvalid_q, wvalid_q, wlast_q, bready_q, done_q, err_q;

    // Buffer bases are stride-aligned and the stride is a multiple of the
    // burst size, so bursts stay size-aligned and never cross a 4 KB line.
    function automatic logic [AW-1:0] buf_base(input logic [1:0] idx);
        return AW'(C_M_TARGET_SLAVE_BASE_ADDR) + AW'(idx) * AW'(FRAME_STRIDE);
    endfunction

    assign burst_cnt_d = burst_cnt_q + 1'b1;
    assign idx_d       = (idx_q == 2'(FRAME_BUF_NUM - 1)) ? 2'd0 : idx_q + 2'd1;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            burst_cnt_q <= '0;
            beat_q      <= '0;
            idx_q       <= 2'd0;
            pend_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A restart request outside IDLE waits for the next WAIT entry;
            // the state arms below clear it where it is consumed.
            if (state_q != S_IDLE && frame_start) pend_q <= 1'b1;
            case (state_q)
                S_IDLE: if (frame_start) begin
                    state_q     <= S_WAIT;
                    burst_cnt_q <= '0;
                    addr_q      <= buf_base(idx_q);
                end
                S_WAIT: if (pend_q) begin
                    // Abandon the current frame, restart at the next buffer.
                    pend_q      <= 1'b0;
                    idx_q       <= idx_d;
                    addr_q      <= buf_base(idx_d);
                    burst_cnt_q <= '0;
                end else if (fifo_rd_cnt >= 12'(C_M_AXI_BURST_LEN)) begin
                    state_q   <= S_AW;
                    awvalid_q <= 1'b1;
                end
                S_AW: if (M_AXI_AWREADY) begin
                    state_q   <= S_W;
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    wlast_q   <= (C_M_AXI_BURST_LEN == 1);
                    beat_q    <= '0;
                end
                S_W: if (M_AXI_WREADY) begin
                    if (wlast_q) begin
                        state_q  <= S_B;
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                    end else begin
                        beat_q  <= beat_q + 1'b1;
                        wlast_q <= (beat_q == BEAT_W'(C_M_AXI_BURST_LEN - 2));
                    end
                end
                S_B: if (M_AXI_BVALID) begin
                    bready_q    <= 1'b0;
                    addr_q      <= addr_q + AW'(BURST_BYTES);
                    burst_cnt_q <= burst_cnt_d;
                    if (M_AXI_BRESP != 2'b00) err_q <= 1'b1;
                    if (burst_cnt_d == BC_W'(FRAME_BURSTS)) begin
                        done_q <= 1'b1;
                        idx_q  <= idx_d;
                        // A start arriving with (or before) the final response
                        // opens the next frame right away, using this advance.
                        if (frame_start || pend_q) begin
                            state_q     <= S_WAIT;
                            pend_q      <= 1'b0;
                            addr_q      <= buf_base(idx_d);
                            burst_cnt_q <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_FRAME_WRITER_STATS_EN
    logic [31:0] burst_total_q;
    logic [15:0] abort_cnt_q;
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            burst_total_q <= '0;
            abort_cnt_q   <= '0;
        end else begin
            if (state_q == S_B && M_AXI_BVALID && burst_total_q != '1)
                burst_total_q <= burst_total_q + 1'b1;
            if (state_q == S_WAIT && pend_q && abort_cnt_q != '1)
                abort_cnt_q <= abort_cnt_q + 1'b1;
        end
    end
    assign burst_total     = burst_total_q;
    assign frame_abort_cnt = abort_cnt_q;
`endif

    assign fifo_rd_en    = wvalid_q & M_AXI_WREADY;
    assign wr_frame_idx  = idx_q;
    assign wr_frame_done = done_q;
    assign wr_err        = err_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0010;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wvalid_q ? fifo_rd_data : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WUSER   = '0;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

    // Single outstanding burst, so the response ID and user bits carry no information.
    logic unused_ok;
    assign unused_ok = &{1'b0, M_AXI_BID, M_AXI_BUSER};
endmodule

// File: tb/tb_axi_frame_writer.sv
module tb_axi_frame_writer;
    localparam int BL = 8;
    localparam int FB = 3;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic fs = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: head word is the running pop count.
    int pushed = 0;
    int popped = 0;
    logic [DW-1:0] fifo_rd_data;
    logic [11:0]   fifo_rd_cnt;
    logic          fifo_rd_en;
    assign fifo_rd_data = {96'd0, 32'(popped)};
    assign fifo_rd_cnt  = 12'(pushed - popped);

    logic [1:0] wr_frame_idx;
    logic wr_frame_done, wr_err;
`ifdef AXI_FRAME_WRITER_STATS_EN
    logic [31:0] burst_total;
    logic [15:0] frame_abort_cnt;
`endif
    logic [0:0] awid, bid;
    logic [31:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, bresp;
    logic awlock, awvalid, wlast, wvalid, bready;
    logic [3:0] awcache, awqos;
    logic [0:0] awuser, wuser, buser;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic awready = 1'b1, wready = 1'b1, bvalid = 1'b0;

    axi_frame_writer #(
        .C_M_AXI_BURST_LEN(BL), .C_M_AXI_DATA_WIDTH(DW), .FRAME_BURSTS(FB)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn), .frame_start(fs),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_cnt(fifo_rd_cnt), .fifo_rd_en(fifo_rd_en),
        .wr_frame_idx(wr_frame_idx), .wr_frame_done(wr_frame_done), .wr_err(wr_err),
`ifdef AXI_FRAME_WRITER_STATS_EN
        .burst_total(burst_total), .frame_abort_cnt(frame_abort_cnt),
`endif
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
        .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
        .M_AXI_AWUSER(awuser), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WUSER(wuser), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BUSER(buser),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );
    assign bid   = 1'b0;
    assign buser = 1'b0;

    // Slave model and protocol monitors.
    logic rand_rdy = 1'b0;
    int err_burst = -1;
    int aw_n = 0, b_n = 0, done_cnt = 0, exp_word = 0, beat = 0;
    int wdata_bad = 0, wlast_bad = 0, hold_bad = 0, rden_bad = 0;
    logic [31:0] aw_log [64];
    logic w_hold, aw_hold, hold_l;
    logic [DW-1:0] hold_d;
    logic [31:0] hold_a;

    always @(negedge clk) begin
        wready  <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        awready <= rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            beat    <= 0;
            w_hold  <= 1'b0;
            aw_hold <= 1'b0;
        end else begin
            if (fifo_rd_en) popped <= popped + 1;
            if (fifo_rd_en !== (wvalid && wready)) rden_bad <= rden_bad + 1;
            if (wr_frame_done) done_cnt <= done_cnt + 1;
            if (awvalid && awready) begin
                aw_log[aw_n] <= awaddr;
                aw_n <= aw_n + 1;
            end
            if (aw_hold && (!awvalid || awaddr !== hold_a)) hold_bad <= hold_bad + 1;
            aw_hold <= awvalid && !awready;
            hold_a  <= awaddr;
            if (w_hold && (!wvalid || wdata !== hold_d || wlast !== hold_l)) hold_bad <= hold_bad + 1;
            w_hold <= wvalid && !wready;
            hold_d <= wdata;
            hold_l <= wlast;
            if (wvalid && wready) begin
                if (wdata !== {96'd0, 32'(exp_word)}) wdata_bad <= wdata_bad + 1;
                exp_word <= exp_word + 1;
                if (wlast !== (beat == BL - 1)) wlast_bad <= wlast_bad + 1;
                beat <= wlast ? 0 : beat + 1;
                if (wlast) begin
                    bvalid <= 1'b1;
                    bresp  <= (b_n == err_burst) ? 2'b10 : 2'b00;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_n    <= b_n + 1;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
    endtask

    task automatic wait_b(input int n);
        int k = 0;
        while (b_n < n && k < 2000) begin @(negedge clk); k++; end
        chk("wait_b", 64'(b_n >= n), 64'd1);
    endtask

    task automatic wait_aw(input int n);
        int k = 0;
        while (aw_n < n && k < 2000) begin @(negedge clk); k++; end
        chk("wait_aw", 64'(aw_n >= n), 64'd1);
    endtask

    task automatic wait_wvalid();
        int k = 0;
        while (!wvalid && k < 2000) begin @(negedge clk); k++; end
        chk("wait_wvalid", 64'(wvalid), 64'd1);
    endtask

    task automatic wait_bvalid();
        int k = 0;
        while (!bvalid && k < 2000) begin @(negedge clk); k++; end
        chk("wait_bvalid", 64'(bvalid), 64'd1);
    endtask

    initial begin
        int aw_before;
        // Reset state
        cyc(3);
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_wvalid", 64'(wvalid), 0);
        chk("rst_bready", 64'(bready), 0);
        chk("rst_rd_en", 64'(fifo_rd_en), 0);
        chk("rst_idx", 64'(wr_frame_idx), 0);
        chk("rst_err", 64'(wr_err), 0);
        chk("rst_awaddr", 64'(awaddr), 0);
        rstn = 1'b1;
        cyc(2);

        // Two bursts back to back from a preloaded FIFO
        pushed = 16;
        cyc(5);
        chk("idle_no_aw", 64'(aw_n), 0);
        pulse_start();
        wait_b(2);
        chk("aw0", 64'(aw_log[0]), 64'h10000000);
        chk("aw1", 64'(aw_log[1]), 64'h10000080);
        chk("awlen", 64'(awlen), 64'd7);
        chk("awsize", 64'(awsize), 64'd4);
        chk("awburst", 64'(awburst), 64'd1);
        chk("awcache", 64'(awcache), 64'd2);
        chk("wstrb", 64'(&wstrb), 64'd1);
        chk("pops16", 64'(popped), 64'd16);

        // Short FIFO stalls, then the third burst completes the frame
        pushed += 5;
        cyc(30);
        chk("stall_partial", 64'(aw_n), 64'd2);
        pushed += 3;
        wait_b(3);
        cyc(2);
        chk("aw2", 64'(aw_log[2]), 64'h10000100);
        chk("done1", 64'(done_cnt), 64'd1);
        chk("idx1", 64'(wr_frame_idx), 64'd1);

        // Idle until frame_start; then a frame with random ready and one SLVERR
        pushed += 8;
        cyc(30);
        chk("idle_wait", 64'(aw_n), 64'd3);
        rand_rdy = 1'b1;
        err_burst = 4;
        pulse_start();
        pushed += 16;
        wait_b(6);
        rand_rdy = 1'b0;
        err_burst = -1;
        cyc(3);
        chk("aw3", 64'(aw_log[3]), 64'h10400000);
        chk("aw5", 64'(aw_log[5]), 64'h10400100);
        chk("err_set", 64'(wr_err), 64'd1);
        chk("done2", 64'(done_cnt), 64'd2);
        chk("idx2", 64'(wr_frame_idx), 64'd2);
        chk("hold", 64'(hold_bad), 0);

        // Restart request during a W phase abandons the frame
        pushed += 24;
        pulse_start();
        wait_aw(7);
        wait_wvalid();
        pulse_start();
        wait_b(9);
        cyc(2);
        chk("aw6", 64'(aw_log[6]), 64'h10800000);
        chk("aw7_abort", 64'(aw_log[7]), 64'h10000000);
        chk("aw8", 64'(aw_log[8]), 64'h10000080);
        chk("no_done_abort", 64'(done_cnt), 64'd2);
        chk("idx_abort", 64'(wr_frame_idx), 64'd0);
        chk("err_sticky", 64'(wr_err), 64'd1);

        // Start arriving with the final BVALID of a frame
        pushed += 16;
        wait_b(9);
        wait_bvalid();
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
        wait_aw(11);
        wait_b(11);
        cyc(2);
        chk("aw9", 64'(aw_log[9]), 64'h10000100);
        chk("aw10_direct", 64'(aw_log[10]), 64'h10400000);
        chk("done3", 64'(done_cnt), 64'd3);
        chk("idx_direct", 64'(wr_frame_idx), 64'd1);
        chk("pops88", 64'(popped), 64'd88);

        // Reset asserted mid-W
        pushed += 8;
        wait_aw(12);
        wait_wvalid();
        rstn = 1'b0;
        #1;
        chk("mid_rst_awvalid", 64'(awvalid), 0);
        chk("mid_rst_wvalid", 64'(wvalid), 0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 0);
        chk("mid_rst_idx", 64'(wr_frame_idx), 0);
        chk("mid_rst_err", 64'(wr_err), 0);
        cyc(2);
        rstn = 1'b1;
        pushed += 8;
        aw_before = aw_n;
        cyc(30);
        chk("post_rst_idle", 64'(aw_n), 64'(aw_before));
        pulse_start();
        wait_b(12);
        cyc(2);
        chk("aw_post_rst", 64'(aw_log[aw_before]), 64'h10000000);
        chk("wdata_seq", 64'(wdata_bad), 0);
        chk("wlast_pos", 64'(wlast_bad), 0);
        chk("rd_en_comb", 64'(rden_bad), 0);
        chk("hold_final", 64'(hold_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
